// File: rtl/param_rom_pkg.sv
// Shared types and helpers for the parameter ROM stream arbiter.
package param_rom_pkg;

    localparam int TAG_ID_W = 4;
    localparam int MAX_REQ  = 1 << TAG_ID_W;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_e;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic                last;
    } rom_tag_t;

    function automatic int min_fifo_depth(input int rom_latency);
        return rom_latency + 1;
    endfunction

    // First requester at or after ptr, wrapping modulo n.
    function automatic int rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        int                  idx;
        logic [TAG_ID_W-1:0] k;
        rr_pick = 0;
        for (int i = n - 1; i >= 0; i--) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            k = TAG_ID_W'(idx);
            if (valid[k]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/param_rom_tag_fifo.sv
// Synchronous FIFO buffering tagged ROM beats ahead of the output stream.
module param_rom_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/param_rom_stream_arbiter.sv
// Round-robin burst arbiter sharing one registered parameter ROM among
// several consumers; beats return as a tagged valid/ready stream.
module param_rom_stream_arbiter
    import param_rom_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int LEN_WIDTH   = 6,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_m1,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic                          rom_ce,
    input  logic [DATA_WIDTH-1:0]         rom_q,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [$clog2(NUM_REQ)-1:0]    data_out_id,
    output logic                          data_out_last,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          busy
);
    localparam int IDW            = $clog2(NUM_REQ);
    localparam int MIN_FIFO_DEPTH = min_fifo_depth(ROM_LATENCY);
    // The address register is the first latency stage; the tag pipe covers the rest.
    localparam int PIPE           = ROM_LATENCY - 1;
    localparam int CW             = $clog2(FIFO_DEPTH + 1);
    localparam int FW             = DATA_WIDTH + $bits(rom_tag_t);

    if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least ROM_LATENCY+1");
    end
    if (ROM_LATENCY < 2) begin : g_lat_chk
        $error("ROM_LATENCY must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_req_chk
        $error("NUM_REQ out of range");
    end

    arb_state_e           state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d, id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
    logic [PIPE-1:0]      pv_q;
    rom_tag_t             pt_q [PIPE];
    logic                 issue, credit;
    int                   pick, inflight;

    logic [FW-1:0]        fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty, fifo_full, fifo_pop;
    rom_tag_t             head_tag;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < PIPE; i++) begin
            if (pv_q[i]) inflight = inflight + 1;
        end
        credit = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        req_ready = '0;
        issue     = 1'b0;
        pick      = rr_pick(MAX_REQ'(req_valid), int'(rr_q), NUM_REQ);
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (i == pick) begin
                            req_ready[i] = 1'b1;
                            addr_d = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                            len_d  = req_len_m1[i*LEN_WIDTH +: LEN_WIDTH];
                        end
                    end
                    id_d    = IDW'(pick);
                    rr_d    = (pick == NUM_REQ - 1) ? '0 : IDW'(pick + 1);
                    beat_d  = '0;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (beat_q == len_q) begin
                        state_d = ARB_IDLE;
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            pv_q[0] <= issue;
            for (int i = 1; i < PIPE; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pt_q[0] <= rom_tag_t'{id: TAG_ID_W'(id_q), last: (beat_q == len_q)};
        for (int i = 1; i < PIPE; i++) pt_q[i] <= pt_q[i-1];
    end

    assign fifo_pop = data_out_valid && data_out_ready;

    param_rom_tag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pv_q[PIPE-1]),
        .data_i  ({rom_q, pt_q[PIPE-1]}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign {data_out, head_tag} = fifo_dout;
    assign data_out_id    = head_tag.id[IDW-1:0];
    assign data_out_last  = head_tag.last;
    assign data_out_valid = !fifo_empty;
    assign rom_addr       = addr_q;
    assign rom_ce         = 1'b1;
    assign busy = (state_q == ARB_ISSUE) || (pv_q != '0) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pv_q[PIPE-1] && fifo_full && !fifo_pop));
            assert (!data_out_valid || (int'(head_tag.id) < NUM_REQ));
        end
    end

endmodule

// File: tb/tb_param_rom_stream_arbiter.sv
// Directed vectors, multi-cycle corner cases and a randomized
// scoreboard run for param_rom_stream_arbiter.
module tb_param_rom_stream_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LW = 6;

    typedef logic [DW+2:0] beat_t;

    typedef struct {
        int          req;
        logic [5:0]  base;
        logic [5:0]  len_m1;
        logic [2:0]  exp_gnt;
        int          exp_lat;
        logic [5:0]  exp_last_addr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_base = '0;
    logic [NR*LW-1:0] req_len_m1 = '0;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    rom_addr;
    logic             rom_ce;
    logic [DW-1:0]    rom_q;
    logic [DW-1:0]    data_out;
    logic [1:0]       data_out_id;
    logic             data_out_last;
    logic             data_out_valid;
    logic             data_out_ready;
    logic             busy;
    logic             dir_ready = 1'b1;
    logic             rnd_ready = 1'b1;
    logic             rnd_mode = 1'b0;

    int    total = 0;
    int    bad = 0;
    beat_t obs[$];
    beat_t expq[$];
    vec_t  vt[4];

    param_rom_stream_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW), .ROM_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_base(req_base),
        .req_len_m1(req_len_m1), .req_ready(req_ready),
        .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_q(rom_q),
        .data_out(data_out), .data_out_id(data_out_id),
        .data_out_last(data_out_last),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .busy(busy)
    );

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        logic [7:0] b;
        b = {2'b00, a};
        return {8'hC0, b, b ^ 8'h5A, b * 8'd3};
    endfunction

    function automatic beat_t mk(input logic [5:0] a, input int id, input logic last);
        return {rom_word(a), 2'(id), last};
    endfunction

    always #5 clk = ~clk;

    assign data_out_ready = rnd_mode ? rnd_ready : dir_ready;

    always @(posedge clk) rom_q <= rom_word(rom_addr);

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready)
            obs.push_back({data_out, data_out_id, data_out_last});
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 64'(busy), 64'd0);
    endtask

    task automatic wait_grant(input string nm, input logic [2:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, 64'(req_ready), 64'(exp));
    endtask

    task automatic compare_streams(input string nm);
        int n;
        check({nm, "_count"}, 64'(obs.size()), 64'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", nm, i), 64'(obs[i]), 64'(expq[i]));
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, n, ng;
        logic [2:0] gnt[4];
        logic [5:0] a;

        vt[0] = '{req: 0, base: 6'd4,  len_m1: 6'd3, exp_gnt: 3'b001, exp_lat: 3, exp_last_addr: 6'd7};
        vt[1] = '{req: 1, base: 6'd62, len_m1: 6'd3, exp_gnt: 3'b010, exp_lat: 3, exp_last_addr: 6'd1};
        vt[2] = '{req: 2, base: 6'd10, len_m1: 6'd0, exp_gnt: 3'b100, exp_lat: 3, exp_last_addr: 6'd10};
        vt[3] = '{req: 0, base: 6'd33, len_m1: 6'd5, exp_gnt: 3'b001, exp_lat: 3, exp_last_addr: 6'd38};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(data_out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rom_ce", 64'(rom_ce), 64'd1);

        for (int v = 0; v < 4; v++) begin
            wait_idle($sformatf("v%0d_idle", v));
            tick();
            req_base = '0;
            req_len_m1 = '0;
            req_base[vt[v].req*AW +: AW] = vt[v].base;
            req_len_m1[vt[v].req*LW +: LW] = vt[v].len_m1;
            req_valid = NR'(1) << vt[v].req;
            wait_grant($sformatf("v%0d_gnt", v), vt[v].exp_gnt);
            tick();
            req_valid = '0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!data_out_valid && lat < 10);
            check($sformatf("v%0d_lat", v), 64'(lat), 64'(vt[v].exp_lat));
            for (int k = 0; k <= int'(vt[v].len_m1); k++) begin
                if (k > 0) @(negedge clk);
                n = 0;
                while (!data_out_valid && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                a = vt[v].base + 6'(k);
                check($sformatf("v%0d_beat%0d", v, k),
                      64'({data_out_valid, data_out, data_out_id, data_out_last}),
                      64'({1'b1, mk(a, vt[v].req, k == int'(vt[v].len_m1))}));
            end
            check($sformatf("v%0d_addr_hold", v), 64'(rom_addr), 64'(vt[v].exp_last_addr));
        end

        // Round robin with all three requesters held valid.
        wait_idle("rr_idle0");
        do_reset();
        obs.delete();
        expq.delete();
        req_base = {6'd24, 6'd16, 6'd8};
        req_len_m1 = {6'd1, 6'd1, 6'd1};
        req_valid = 3'b111;
        ng = 0;
        n = 0;
        for (int i = 0; i < 4; i++) gnt[i] = '0;
        while (ng < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) begin
                gnt[ng] = req_ready;
                ng++;
            end
        end
        tick();
        req_valid = '0;
        check("rr_g0", 64'(gnt[0]), 64'(3'b001));
        check("rr_g1", 64'(gnt[1]), 64'(3'b010));
        check("rr_g2", 64'(gnt[2]), 64'(3'b100));
        check("rr_g3", 64'(gnt[3]), 64'(3'b001));
        wait_idle("rr_idle1");
        expq.push_back(mk(6'd8, 0, 1'b0));
        expq.push_back(mk(6'd9, 0, 1'b1));
        expq.push_back(mk(6'd16, 1, 1'b0));
        expq.push_back(mk(6'd17, 1, 1'b1));
        expq.push_back(mk(6'd24, 2, 1'b0));
        expq.push_back(mk(6'd25, 2, 1'b1));
        expq.push_back(mk(6'd8, 0, 1'b0));
        expq.push_back(mk(6'd9, 0, 1'b1));
        compare_streams("rr");

        // Output stalled for ten cycles during an eight-beat burst.
        tick();
        obs.delete();
        expq.delete();
        dir_ready = 1'b0;
        req_base = '0;
        req_len_m1 = '0;
        req_base[0 +: AW] = 6'd20;
        req_len_m1[0 +: LW] = 6'd7;
        req_valid = 3'b001;
        wait_grant("stall_gnt", 3'b001);
        tick();
        req_valid = '0;
        repeat (9) tick();
        @(negedge clk);
        check("stall_addr", 64'(rom_addr), 64'd24);
        check("stall_valid", 64'(data_out_valid), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_head", 64'({data_out, data_out_id, data_out_last}), 64'(mk(6'd20, 0, 1'b0)));
        repeat (3) tick();
        @(negedge clk);
        check("stall_addr2", 64'(rom_addr), 64'd24);
        check("stall_head2", 64'({data_out, data_out_id, data_out_last}), 64'(mk(6'd20, 0, 1'b0)));
        tick();
        dir_ready = 1'b1;
        wait_idle("stall_idle");
        for (int k = 0; k < 8; k++) expq.push_back(mk(6'd20 + 6'(k), 0, k == 7));
        compare_streams("stall");

        // Reset with two beats buffered, requester 1 leaves rr at 2.
        tick();
        obs.delete();
        expq.delete();
        dir_ready = 1'b0;
        req_base = '0;
        req_len_m1 = '0;
        req_base[1*AW +: AW] = 6'd40;
        req_len_m1[1*LW +: LW] = 6'd5;
        req_valid = 3'b010;
        wait_grant("mrst_gnt", 3'b010);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        check("mrst_pre_valid", 64'(data_out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 64'(data_out_valid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_addr", 64'(rom_addr), 64'd0);
        tick();
        dir_ready = 1'b1;
        req_base[1*AW +: AW] = 6'd50;
        req_len_m1[1*LW +: LW] = 6'd1;
        req_base[2*AW +: AW] = 6'd60;
        req_len_m1[2*LW +: LW] = 6'd0;
        req_valid = 3'b110;
        wait_grant("mrst_rr", 3'b010);
        tick();
        req_valid = '0;
        wait_idle("mrst_idle");
        expq.push_back(mk(6'd50, 1, 1'b0));
        expq.push_back(mk(6'd51, 1, 1'b1));
        compare_streams("mrst");

        // Random bursts with random output backpressure.
        tick();
        obs.delete();
        expq.delete();
        rnd_mode = 1'b1;
        for (int b = 0; b < 200; b++) begin
            int r, l;
            logic [5:0] base;
            r = $urandom_range(0, 2);
            base = 6'($urandom_range(0, 63));
            l = $urandom_range(0, 7);
            tick();
            req_base = '0;
            req_len_m1 = '0;
            req_base[r*AW +: AW] = base;
            req_len_m1[r*LW +: LW] = 6'(l);
            req_valid = NR'(1) << r;
            wait_grant($sformatf("rnd_gnt%0d", b), 3'(NR'(1) << r));
            tick();
            req_valid = '0;
            for (int k = 0; k <= l; k++) expq.push_back(mk(base + 6'(k), r, k == l));
        end
        wait_idle("rnd_idle");
        rnd_mode = 1'b0;
        compare_streams("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
